// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel selector.
package mux_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mux_mode_t;

    localparam int unsigned DEFAULT_DWELL = 50_000_000;

    // Round-robin increment with wrap from nch-1 back to 0.
    function automatic int unsigned next_idx(input int unsigned cur, input int unsigned nch);
        return (cur >= nch - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_timer.sv
// Dwell counter for auto-scan: counts 0..DWELL-1 while enabled, pulses tick on the last count.
module dwell_timer
    import mux_pkg::*;
#(
    parameter int unsigned DWELL = DEFAULT_DWELL
) (
    input  logic clk_2,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual select or timed round-robin scan.
// Optional channel masking is enabled by defining MUX_MASK_EN.
module mux_scan
    import mux_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned W     = 2,
    parameter  int unsigned DWELL = DEFAULT_DWELL,
    localparam int unsigned IW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [NCH*W-1:0]  din,
    input  logic [IW-1:0]     sel,
    input  logic              mode,
    input  logic              hold,
`ifdef MUX_MASK_EN
    input  logic [NCH-1:0]    ch_mask,
`endif
    output logic [W-1:0]      dout,
    output logic [IW-1:0]     ch_idx,
    output logic              changed
);

    mux_mode_t     mode_e;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          chg_q, chg_d;
    logic          tick;
    logic          sel_ok;
    logic [IW-1:0] adv_idx;

    assign mode_e = mux_mode_t'(mode);

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk_2 (clk_2),
        .reset (reset),
        .en    ((mode_e == AUTO) && !hold),
        .clr   (mode_e == MANUAL),
        .tick  (tick)
    );

`ifdef MUX_MASK_EN
    // Search upward from the current index; k == NCH lands back on idx_q, so a
    // lone enabled channel or an all-zero mask leaves the index unchanged.
    always_comb begin
        int unsigned cand;
        logic        found;
        adv_idx = idx_q;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = 32'(idx_q) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            if (!found && ch_mask[cand]) begin
                adv_idx = IW'(cand);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ok = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (32'(sel) == k && ch_mask[k]) begin
                sel_ok = 1'b1;
            end
        end
    end
`else
    assign adv_idx = IW'(next_idx(32'(idx_q), NCH));
    assign sel_ok  = (32'(sel) < NCH);
`endif

    always_comb begin
        idx_d = idx_q;
        if (!hold) begin
            if (mode_e == MANUAL) begin
                if (sel_ok) begin
                    idx_d = sel;
                end
            end else if (tick) begin
                idx_d = adv_idx;
            end
        end

        dout_d = dout_q;
        if (!hold) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (IW'(k) == idx_d) begin
                    dout_d = din[k*W +: W];
                end
            end
        end

        chg_d = (idx_d != idx_q);
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            idx_q  <= '0;
            dout_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            dout_q <= dout_d;
            chg_q  <= chg_d;
        end
    end

    assign dout    = dout_q;
    assign ch_idx  = idx_q;
    assign changed = chg_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed-vector bench for mux_scan: manual select, timed scan, hold, reset, wrap, masking.
module tb_mux_scan;

    logic clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    int errors = 0;
    int checks = 0;

    // u4: NCH=4, W=2, DWELL=3
    logic       a_rst, a_mode, a_hold;
    logic [1:0] a_sel;
    logic [7:0] a_din;
    logic [1:0] a_dout, a_idx;
    logic       a_chg;

    // u3: NCH=3, W=2, DWELL=2
    logic       b_rst, b_mode, b_hold;
    logic [1:0] b_sel;
    logic [5:0] b_din;
    logic [1:0] b_dout, b_idx;
    logic       b_chg;

    // u1: NCH=4, W=2, DWELL=1
    logic       c_rst, c_mode, c_hold;
    logic [1:0] c_sel;
    logic [7:0] c_din;
    logic [1:0] c_dout, c_idx;
    logic       c_chg;
`ifdef MUX_MASK_EN
    logic [3:0] a_mask = 4'b1111;
    logic [2:0] b_mask = 3'b111;
    logic [3:0] c_mask = 4'b1111;
`endif

    mux_scan #(.NCH(4), .W(2), .DWELL(3)) u4 (
        .clk_2(clk_2), .reset(a_rst), .din(a_din), .sel(a_sel), .mode(a_mode), .hold(a_hold),
`ifdef MUX_MASK_EN
        .ch_mask(a_mask),
`endif
        .dout(a_dout), .ch_idx(a_idx), .changed(a_chg)
    );

    mux_scan #(.NCH(3), .W(2), .DWELL(2)) u3 (
        .clk_2(clk_2), .reset(b_rst), .din(b_din), .sel(b_sel), .mode(b_mode), .hold(b_hold),
`ifdef MUX_MASK_EN
        .ch_mask(b_mask),
`endif
        .dout(b_dout), .ch_idx(b_idx), .changed(b_chg)
    );

    mux_scan #(.NCH(4), .W(2), .DWELL(1)) u1 (
        .clk_2(clk_2), .reset(c_rst), .din(c_din), .sel(c_sel), .mode(c_mode), .hold(c_hold),
`ifdef MUX_MASK_EN
        .ch_mask(c_mask),
`endif
        .dout(c_dout), .ch_idx(c_idx), .changed(c_chg)
    );

    typedef struct {
        logic       rst;
        logic       md;
        logic       hd;
        logic [1:0] sel;
        logic [7:0] din;
        logic [1:0] e_idx;
        logic [1:0] e_dout;
        logic       e_chg;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic md, input logic hd, input logic [1:0] sel,
                       input logic [7:0] din, input logic [1:0] ei, input logic [1:0] ed,
                       input logic ec);
        vec_t v;
        v.rst = rst; v.md = md; v.hd = hd; v.sel = sel; v.din = din;
        v.e_idx = ei; v.e_dout = ed; v.e_chg = ec;
        vq.push_back(v);
    endtask

    task automatic step_b(input logic rst, input logic md, input logic [1:0] sel);
        b_rst = rst; b_mode = md; b_hold = 1'b0; b_sel = sel;
        @(posedge clk_2);
        #1;
    endtask

    task automatic step_c(input logic rst, input logic md, input logic [1:0] sel);
        c_rst = rst; c_mode = md; c_hold = 1'b0; c_sel = sel;
        @(posedge clk_2);
        #1;
    endtask

    localparam logic [7:0] D = 8'b11_10_01_00;

    initial begin
        a_rst = 1'b1; a_mode = 1'b0; a_hold = 1'b0; a_sel = '0; a_din = D;
        b_rst = 1'b1; b_mode = 1'b0; b_hold = 1'b0; b_sel = '0; b_din = 6'b10_01_11;
        c_rst = 1'b1; c_mode = 1'b0; c_hold = 1'b0; c_sel = '0; c_din = D;

        //   rst  md  hd  sel  din     idx dout chg
        add(1, 0, 0, 0, D,      0, 0, 0);  // reset
        add(0, 0, 0, 2, D,      2, 2, 1);  // manual select
        add(0, 0, 0, 2, D,      2, 2, 0);
        add(0, 0, 0, 2, 8'hD4,  2, 1, 0);  // live din tracking
        add(0, 0, 0, 0, D,      0, 0, 1);
        add(0, 0, 1, 3, D,      0, 0, 0);  // hold ignores sel
        add(1, 1, 0, 0, D,      0, 0, 0);  // reset into auto
        add(0, 1, 0, 0, D,      0, 0, 0);
        add(0, 1, 0, 0, D,      0, 0, 0);
        add(0, 1, 0, 0, D,      1, 1, 1);
        add(0, 1, 0, 0, D,      1, 1, 0);
        add(0, 1, 0, 0, D,      1, 1, 0);
        add(0, 1, 0, 0, D,      2, 2, 1);
        add(0, 1, 0, 0, D,      2, 2, 0);  // count now 1
        add(0, 1, 1, 0, 8'h00,  2, 2, 0);  // hold x5, din changes ignored
        add(0, 1, 1, 0, 8'h00,  2, 2, 0);
        add(0, 1, 1, 0, 8'h00,  2, 2, 0);
        add(0, 1, 1, 0, 8'h00,  2, 2, 0);
        add(0, 1, 1, 0, 8'h00,  2, 2, 0);
        add(0, 1, 0, 0, D,      2, 2, 0);  // remaining dwell
        add(0, 1, 0, 0, D,      3, 3, 1);
        add(0, 1, 0, 0, D,      3, 3, 0);
        add(0, 1, 0, 0, D,      3, 3, 0);
        add(0, 1, 0, 0, D,      0, 0, 1);  // wrap 3->0
        add(0, 1, 0, 0, D,      0, 0, 0);
        add(0, 1, 0, 0, D,      0, 0, 0);
        add(0, 1, 0, 0, D,      1, 1, 1);
        add(0, 1, 0, 0, D,      1, 1, 0);
        add(0, 1, 0, 0, D,      1, 1, 0);
        add(0, 1, 0, 0, D,      2, 2, 1);
        add(0, 1, 0, 0, D,      2, 2, 0);  // idx 2, count 1
        add(1, 1, 1, 0, D,      0, 0, 0);  // reset beats hold
        add(0, 1, 0, 0, D,      0, 0, 0);
        add(0, 1, 0, 0, D,      0, 0, 0);
        add(0, 1, 0, 0, D,      1, 1, 1);  // full dwell at 0
        add(0, 1, 0, 0, D,      1, 1, 0);  // count 1
        add(0, 0, 0, 3, D,      3, 3, 1);  // to manual, counter clears
        add(0, 1, 0, 0, D,      3, 3, 0);
        add(0, 1, 0, 0, D,      3, 3, 0);
        add(0, 1, 0, 0, D,      0, 0, 1);

        @(negedge clk_2);
        foreach (vq[i]) begin
            a_rst = vq[i].rst; a_mode = vq[i].md; a_hold = vq[i].hd;
            a_sel = vq[i].sel; a_din = vq[i].din;
            @(posedge clk_2);
            #1;
            chk($sformatf("v%0d ch_idx", i),  8'(a_idx),  8'(vq[i].e_idx));
            chk($sformatf("v%0d dout", i),    8'(a_dout), 8'(vq[i].e_dout));
            chk($sformatf("v%0d changed", i), 8'(a_chg),  8'(vq[i].e_chg));
        end

        // NCH=3: out-of-range select and non-power-of-two wrap
        step_b(1, 0, 0);
        chk("n3 rst idx", 8'(b_idx), 8'd0);
        chk("n3 rst dout", 8'(b_dout), 8'd0);
        step_b(0, 0, 1);
        chk("n3 sel1 idx", 8'(b_idx), 8'd1);
        chk("n3 sel1 dout", 8'(b_dout), 8'b01);
        chk("n3 sel1 chg", 8'(b_chg), 8'd1);
        step_b(0, 0, 3);
        chk("n3 oor idx", 8'(b_idx), 8'd1);
        chk("n3 oor chg", 8'(b_chg), 8'd0);
        chk("n3 oor dout", 8'(b_dout), 8'b01);
        step_b(0, 0, 2);
        chk("n3 sel2 idx", 8'(b_idx), 8'd2);
        chk("n3 sel2 dout", 8'(b_dout), 8'b10);
        step_b(0, 1, 0);
        chk("n3 auto dwell idx", 8'(b_idx), 8'd2);
        step_b(0, 1, 0);
        chk("n3 wrap idx", 8'(b_idx), 8'd0);
        chk("n3 wrap dout", 8'(b_dout), 8'b11);
        chk("n3 wrap chg", 8'(b_chg), 8'd1);

        // DWELL=1: advance every cycle
        step_c(1, 1, 0);
        chk("d1 rst idx", 8'(c_idx), 8'd0);
        for (int k = 1; k <= 4; k++) begin
            step_c(0, 1, 0);
            chk($sformatf("d1 step%0d idx", k), 8'(c_idx), 8'(k % 4));
            chk($sformatf("d1 step%0d chg", k), 8'(c_chg), 8'd1);
        end
`ifdef MUX_MASK_EN
        c_mask = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step_c(0, 1, 0);
            chk($sformatf("mask step%0d idx", k), 8'(c_idx), (k % 2 == 0) ? 8'd1 : 8'd3);
            chk($sformatf("mask step%0d chg", k), 8'(c_chg), 8'd1);
        end
        c_mask = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            step_c(0, 1, 0);
            chk($sformatf("mask0 step%0d idx", k), 8'(c_idx), 8'd3);
            chk($sformatf("mask0 step%0d chg", k), 8'(c_chg), 8'd0);
        end
        c_mask = 4'b1010;
        step_c(0, 0, 0);
        chk("mask manual blocked idx", 8'(c_idx), 8'd3);
        chk("mask manual blocked chg", 8'(c_chg), 8'd0);
        step_c(0, 0, 1);
        chk("mask manual ok idx", 8'(c_idx), 8'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer; successor to the SWI-driven 2:1 LED selector.
- Manual mode: the output channel is chosen by a select input.
- Auto mode: the channel index rotates round-robin every DWELL clock cycles.
- Drives LED/SEG display paths from top; output registered, index and change strobe exposed for LCD debug.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 2, bits per channel.
- DWELL, 50000000, cycles each channel is shown in auto mode (>=1).
- IW, $clog2(NCH) (min 1), index width; derived, not overridden.

Ports:
- clk_2  input  1  system clock
- reset  input  1  synchronous, active-high reset
- din  input  NCH*W  packed channels; channel k = din[k*W +: W]
- sel  input  IW  manual channel select
- mode  input  1  0 = MANUAL, 1 = AUTO
- hold  input  1  freeze index, output and dwell counter
- dout  output  W  registered selected channel data
- ch_idx  output  IW  currently selected channel
- changed  output  1  one-cycle pulse when ch_idx changes

Behaviour:
- Reset (sync, active-high, highest priority): ch_idx=0, dout=0, changed=0, dwell counter=0. If reset and hold are both high, reset wins.
- Next index (combinational):
  - hold=1: next = ch_idx.
  - MANUAL: next = sel if sel<NCH, else ch_idx (out-of-range sel ignored).
  - AUTO: next = (ch_idx==NCH-1 ? 0 : ch_idx+1) when cnt==DWELL-1, else ch_idx.
- Every edge without reset:
  - ch_idx <= next.
  - dout <= din slice at next, or unchanged when hold=1.
  - changed <= (next != ch_idx).
- Latency: a sel change appears on ch_idx and dout at the next edge, 1 cycle later. With hold=0, dout tracks live din of the selected channel with 1-cycle latency.
- Dwell counter (AUTO, hold=0): counts 0..DWELL-1, wraps to 0 on the advance cycle. DWELL=1 advances every cycle.
- Counter in MANUAL: held at 0.
- Mode change MANUAL->AUTO: scan starts from the current ch_idx, counter starts at 0, so the first advance comes DWELL cycles later.
- Mode change AUTO->MANUAL: next edge loads sel and counter clears.
- Reset mid-scan: index returns to 0, counter to 0.
- Index wrap: NCH-1 -> 0.
- changed is never asserted during hold or reset.

Optional Feature:
- MUX_MASK_EN defined:
  - Adds port ch_mask input NCH.
  - AUTO advance goes to the next index above ch_idx, with wrap, whose mask bit is 1.
  - All mask bits 0: index holds, counter keeps wrapping, no changed pulse.
  - MANUAL select of a masked channel is ignored, like an out-of-range sel.
- MUX_MASK_EN undefined:
  - No ch_mask port; all channels are enabled.

Decomposition:
- Package mux_pkg:
  - typedef enum logic {MANUAL=1'b0, AUTO=1'b1} mux_mode_t.
  - Function next_idx(cur, nch) for wrap-around increment.
  - Constant DEFAULT_DWELL.
- Sub-module dwell_timer (params DWELL):
  - Inputs: clk_2, reset, en, clr.
  - Output: tick when the count reaches DWELL-1.
  - mux_scan instantiates one dwell_timer.

Test Plan:
1. NCH=4, W=2, din=8'b11_10_01_00, MANUAL, sel=2 after reset -> next cycle ch_idx=2, dout=2'b10, changed=1 for one cycle; sel held -> changed=0.
2. AUTO, DWELL=3, hold=0 from reset -> ch_idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; changed pulses exactly at each transition, including 3->0.
3. AUTO mid-dwell, hold=1 for 5 cycles -> ch_idx, dout and counter frozen, changed=0; hold release -> remaining dwell cycles complete before advance.
4. NCH=3, MANUAL, sel=3 (out of range) from ch_idx=1 -> ch_idx stays 1, no changed pulse.
5. AUTO at ch_idx=2, count=1, reset=1 for one cycle -> ch_idx=0, dout=0, changed=0; scan restarts with a full DWELL at index 0.
6. MUX_MASK_EN, NCH=4, DWELL=1, ch_mask=4'b1010, AUTO -> ch_idx alternates 1,3,1,3; ch_mask=0 -> index holds, changed=0.
